// File: rtl/cpu_pkg.sv
// Shared types and constants for the decode sink: FSM states, jump opcodes
// and the architectural link register index.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN,
    REDIR,
    SQUASH
  } sink_state_e;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] LINK_REG = 5'd1;

endpackage

// File: rtl/jump_target_calc.sv
// Combinational JAL/JALR target resolution: base select, add and word-align.
// is_ctl flags an opcode that can redirect fetch.
module jump_target_calc
  import cpu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] pc,
  input  logic [4:0]  rs1,
  input  logic [31:0] imm,
  input  logic [31:0] link,
  output logic        is_ctl,
  output logic [31:0] target
);

  logic [31:0] base;

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    base   = '0;
    is_ctl = 1'b0;
    case (opcode)
      OPC_JAL: begin
        is_ctl = 1'b1;
        base   = pc;
      end
      OPC_JALR: begin
        is_ctl = 1'b1;
        // Only x1 is shadowed; x0 and all other sources resolve to zero.
        base   = (rs1 == LINK_REG) ? link : '0;
      end
      default: ;
    endcase
  end

  assign target = (base + imm) & ~32'h3;

endmodule

// File: rtl/decode_sink.sv
// Consumer end of the decoded-bundle interface: retires beats, redirects
// fetch on jumps, then squashes wrong-path beats. DECODE_SINK_STATS_EN adds counters.
module decode_sink
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [31:0] dec_pc_i,
  input  logic [31:0] dec_instr_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rd_i,
  input  logic [31:0] dec_imm_i,
  input  logic        dec_is_jump_i,
  input  logic        stall_i,
  output logic        redir_valid_o,
  output logic [31:0] redir_target_o,
  output logic        retire_valid_o,
  output logic [31:0] retire_pc_o,
  output logic [31:0] retire_count_o
`ifdef DECODE_SINK_STATS_EN
  ,
  output logic [15:0] squash_count_o,
  output logic [15:0] redir_count_o
`endif
);

  localparam logic [3:0] SQUASH_LOAD = 4'(SQUASH_CYCLES);

  sink_state_e state_q, state_d;
  logic [3:0]  squash_cnt_q;
  logic [31:0] link_q;
  logic        is_ctl;
  logic [31:0] target;
  logic        accept;
  logic        run_accept;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^dec_instr_i[31:7];

  jump_target_calc u_target (
    .opcode (dec_instr_i[6:0]),
    .pc     (dec_pc_i),
    .rs1    (dec_rs1_i),
    .imm    (dec_imm_i),
    .link   (link_q),
    .is_ctl (is_ctl),
    .target (target)
  );

  always_comb begin
    dec_ready_o = 1'b0;
    state_d     = state_q;
    case (state_q)
      RUN: begin
        dec_ready_o = !stall_i;
        if (dec_valid_i && !stall_i && dec_is_jump_i && is_ctl) state_d = REDIR;
      end
      REDIR:   state_d = SQUASH;
      SQUASH: begin
        dec_ready_o = 1'b1;
        if (squash_cnt_q <= 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign accept     = dec_valid_i && dec_ready_o;
  assign run_accept = accept && (state_q == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      redir_valid_o  <= 1'b0;
      redir_target_o <= '0;
      retire_valid_o <= 1'b0;
      retire_pc_o    <= '0;
      retire_count_o <= '0;
      link_q         <= PC_RESET;
      squash_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      redir_valid_o  <= (state_d == REDIR);
      retire_valid_o <= run_accept;
      if (run_accept) begin
        retire_pc_o    <= dec_pc_i;
        retire_count_o <= retire_count_o + 32'd1;
        // The target above was computed from the old link value.
        if (dec_is_jump_i && dec_rd_i == LINK_REG) link_q <= dec_pc_i + 32'd4;
      end
      if (state_d == REDIR) redir_target_o <= target;
      if (state_q == REDIR)       squash_cnt_q <= SQUASH_LOAD;
      else if (state_q == SQUASH) squash_cnt_q <= squash_cnt_q - 4'd1;
    end
  end

`ifdef DECODE_SINK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_count_o <= '0;
      redir_count_o  <= '0;
    end else begin
      if (accept && state_q == SQUASH && squash_count_o != 16'hFFFF)
        squash_count_o <= squash_count_o + 16'd1;
      if (state_q == REDIR && redir_count_o != 16'hFFFF)
        redir_count_o <= redir_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_sink.sv
// Directed testbench for decode_sink; inputs change and outputs are
// sampled on the falling edge. Stats checks build with DECODE_SINK_STATS_EN.
module tb_decode_sink;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] JAL_RD0   = 32'h0000_006F;
  localparam logic [31:0] JAL_RD1   = 32'h0000_00EF;
  localparam logic [31:0] JALR_X1   = 32'h0000_8067;
  localparam logic [31:0] JALR_X1X1 = 32'h0000_80E7;
  localparam logic [31:0] JALR_X2   = 32'h0001_0067;

  logic        clk;
  logic        rst;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [31:0] dec_pc_i;
  logic [31:0] dec_instr_i;
  logic [4:0]  dec_rs1_i;
  logic [4:0]  dec_rd_i;
  logic [31:0] dec_imm_i;
  logic        dec_is_jump_i;
  logic        stall_i;
  logic        redir_valid_o;
  logic [31:0] redir_target_o;
  logic        retire_valid_o;
  logic [31:0] retire_pc_o;
  logic [31:0] retire_count_o;
`ifdef DECODE_SINK_STATS_EN
  logic [15:0] squash_count_o;
  logic [15:0] redir_count_o;
`endif

  int checks = 0;
  int errors = 0;

  decode_sink #(.PC_RESET(32'h0), .SQUASH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .dec_valid_i    (dec_valid_i),
    .dec_ready_o    (dec_ready_o),
    .dec_pc_i       (dec_pc_i),
    .dec_instr_i    (dec_instr_i),
    .dec_rs1_i      (dec_rs1_i),
    .dec_rd_i       (dec_rd_i),
    .dec_imm_i      (dec_imm_i),
    .dec_is_jump_i  (dec_is_jump_i),
    .stall_i        (stall_i),
    .redir_valid_o  (redir_valid_o),
    .redir_target_o (redir_target_o),
    .retire_valid_o (retire_valid_o),
    .retire_pc_o    (retire_pc_o),
    .retire_count_o (retire_count_o)
`ifdef DECODE_SINK_STATS_EN
    ,
    .squash_count_o (squash_count_o),
    .redir_count_o  (redir_count_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic set_beat(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] rs1, input logic [4:0] rd,
                          input logic [31:0] imm, input logic jump);
    dec_valid_i   = v;
    dec_pc_i      = pc;
    dec_instr_i   = instr;
    dec_rs1_i     = rs1;
    dec_rd_i      = rd;
    dec_imm_i     = imm;
    dec_is_jump_i = jump;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b0) begin errors++; $display("FAIL rst_redir_valid got %b exp 0", redir_valid_o); end
    checks++; if (redir_target_o !== 32'h0) begin errors++; $display("FAIL rst_redir_target got %h exp 0", redir_target_o); end
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL rst_retire_valid got %b exp 0", retire_valid_o); end
    checks++; if (retire_pc_o !== 32'h0) begin errors++; $display("FAIL rst_retire_pc got %h exp 0", retire_pc_o); end
    checks++; if (retire_count_o !== 32'h0) begin errors++; $display("FAIL rst_retire_count got %0d exp 0", retire_count_o); end
    rst = 1'b0;
    #1;
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", dec_ready_o); end
  endtask

  task automatic test_alu_beats;
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, 32'(i * 4), NOP, 5'd0, 5'd0, 32'h0, 1'b0);
      @(negedge clk);
      checks++; if (retire_valid_o !== 1'b1) begin errors++; $display("FAIL alu_retire_valid[%0d] got %b exp 1", i, retire_valid_o); end
      checks++; if (retire_pc_o !== 32'(i * 4)) begin errors++; $display("FAIL alu_retire_pc[%0d] got %h exp %h", i, retire_pc_o, 32'(i * 4)); end
      checks++; if (redir_valid_o !== 1'b0) begin errors++; $display("FAIL alu_redir[%0d] got %b exp 0", i, redir_valid_o); end
    end
    dec_valid_i = 1'b0;
    checks++; if (retire_count_o !== 32'd3) begin errors++; $display("FAIL alu_count got %0d exp 3", retire_count_o); end
    @(negedge clk);
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL alu_retire_drop got %b exp 0", retire_valid_o); end
  endtask

  task automatic test_jal;
    set_beat(1'b1, 32'h8, JAL_RD1, 5'd0, 5'd1, 32'h10, 1'b1);
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b1) begin errors++; $display("FAIL jal_redir_valid got %b exp 1", redir_valid_o); end
    checks++; if (redir_target_o !== 32'h18) begin errors++; $display("FAIL jal_target got %h exp 18", redir_target_o); end
    checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL jal_ready_in_redir got %b exp 0", dec_ready_o); end
    checks++; if (retire_pc_o !== 32'h8) begin errors++; $display("FAIL jal_retire_pc got %h exp 8", retire_pc_o); end
    checks++; if (retire_count_o !== 32'd4) begin errors++; $display("FAIL jal_count got %0d exp 4", retire_count_o); end
    set_beat(1'b1, 32'h18, NOP, 5'd0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b0) begin errors++; $display("FAIL jal_pulse_width got %b exp 0", redir_valid_o); end
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL jal_ready_squash got %b exp 1", dec_ready_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL jal_squash_retire[%0d] got %b exp 0", i, retire_valid_o); end
      dec_pc_i = 32'h1C + 32'(i * 4);
    end
    checks++; if (retire_count_o !== 32'd4) begin errors++; $display("FAIL jal_squash_count got %0d exp 4", retire_count_o); end
    @(negedge clk);
    checks++; if (retire_valid_o !== 1'b1) begin errors++; $display("FAIL jal_resume_valid got %b exp 1", retire_valid_o); end
    checks++; if (retire_pc_o !== 32'h20) begin errors++; $display("FAIL jal_resume_pc got %h exp 20", retire_pc_o); end
    checks++; if (retire_count_o !== 32'd5) begin errors++; $display("FAIL jal_resume_count got %0d exp 5", retire_count_o); end
    dec_valid_i = 1'b0;
  endtask

  task automatic test_jalr;
    set_beat(1'b1, 32'h30, JALR_X1, 5'd1, 5'd0, 32'h4, 1'b1);
    @(negedge clk);
    checks++; if (redir_target_o !== 32'h10) begin errors++; $display("FAIL jalr_link_target got %h exp 10", redir_target_o); end
    dec_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    set_beat(1'b1, 32'h40, JALR_X1X1, 5'd1, 5'd1, 32'h3, 1'b1);
    @(negedge clk);
    checks++; if (redir_target_o !== 32'hC) begin errors++; $display("FAIL jalr_align_target got %h exp c", redir_target_o); end
    dec_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    set_beat(1'b1, 32'h50, JALR_X1, 5'd1, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    checks++; if (redir_target_o !== 32'h44) begin errors++; $display("FAIL jalr_new_link got %h exp 44", redir_target_o); end
    dec_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    set_beat(1'b1, 32'h60, JALR_X2, 5'd2, 5'd0, 32'h103, 1'b1);
    @(negedge clk);
    checks++; if (redir_target_o !== 32'h100) begin errors++; $display("FAIL jalr_other_rs1 got %h exp 100", redir_target_o); end
    checks++; if (retire_count_o !== 32'd9) begin errors++; $display("FAIL jalr_count got %0d exp 9", retire_count_o); end
    dec_valid_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall;
    stall_i = 1'b1;
    set_beat(1'b1, 32'h100, NOP, 5'd0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, dec_ready_o); end
      @(negedge clk);
      checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL stall_retire[%0d] got %b exp 0", i, retire_valid_o); end
    end
    checks++; if (retire_count_o !== 32'd9) begin errors++; $display("FAIL stall_count got %0d exp 9", retire_count_o); end
    stall_i = 1'b0;
    #1;
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", dec_ready_o); end
    @(negedge clk);
    checks++; if (retire_valid_o !== 1'b1 || retire_pc_o !== 32'h100) begin errors++; $display("FAIL stall_release_retire got %b/%h exp 1/100", retire_valid_o, retire_pc_o); end
    checks++; if (retire_count_o !== 32'd10) begin errors++; $display("FAIL stall_release_count got %0d exp 10", retire_count_o); end
    dec_valid_i = 1'b0;
  endtask

  task automatic test_jump_in_squash;
    set_beat(1'b1, 32'h200, JAL_RD0, 5'd0, 5'd0, 32'h40, 1'b1);
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b1 || redir_target_o !== 32'h240) begin errors++; $display("FAIL sqj_first got %b/%h exp 1/240", redir_valid_o, redir_target_o); end
    set_beat(1'b1, 32'h300, JAL_RD0, 5'd0, 5'd0, 32'h80, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (redir_valid_o !== 1'b0 || retire_valid_o !== 1'b0) begin errors++; $display("FAIL sqj_drop[%0d] got redir %b retire %b exp 0/0", i, redir_valid_o, retire_valid_o); end
    end
    dec_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b0) begin errors++; $display("FAIL sqj_no_second_redir got %b exp 0", redir_valid_o); end
    checks++; if (redir_target_o !== 32'h240) begin errors++; $display("FAIL sqj_target_hold got %h exp 240", redir_target_o); end
    checks++; if (retire_count_o !== 32'd11) begin errors++; $display("FAIL sqj_count got %0d exp 11", retire_count_o); end
  endtask

  task automatic test_reset_mid_squash;
    set_beat(1'b1, 32'h400, JAL_RD1, 5'd0, 5'd1, 32'h8, 1'b1);
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b1) begin errors++; $display("FAIL rms_redir got %b exp 1", redir_valid_o); end
    dec_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({redir_valid_o, retire_valid_o} !== 2'b00 || redir_target_o !== 32'h0 || retire_pc_o !== 32'h0 || retire_count_o !== 32'h0)
      begin errors++; $display("FAIL rms_async_clear got %b %b %h %h %0d exp all 0", redir_valid_o, retire_valid_o, redir_target_o, retire_pc_o, retire_count_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL rms_ready got %b exp 1", dec_ready_o); end
    set_beat(1'b1, 32'h500, JALR_X1, 5'd1, 5'd0, 32'h8, 1'b1);
    @(negedge clk);
    checks++; if (redir_valid_o !== 1'b1 || redir_target_o !== 32'h8) begin errors++; $display("FAIL rms_link_reset got %b/%h exp 1/8", redir_valid_o, redir_target_o); end
    checks++; if (retire_count_o !== 32'd1) begin errors++; $display("FAIL rms_count got %0d exp 1", retire_count_o); end
    dec_valid_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef DECODE_SINK_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (redir_count_o !== 16'd0 || squash_count_o !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", redir_count_o, squash_count_o); end
    set_beat(1'b1, 32'h0, JAL_RD0, 5'd0, 5'd0, 32'h10, 1'b1);
    repeat (8) @(negedge clk);
    dec_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (redir_count_o !== 16'd2) begin errors++; $display("FAIL stats_redir got %0d exp 2", redir_count_o); end
    checks++; if (squash_count_o !== 16'd4) begin errors++; $display("FAIL stats_squash got %0d exp 4", squash_count_o); end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    stall_i = 1'b0;
    set_beat(1'b0, 32'h0, NOP, 5'd0, 5'd0, 32'h0, 1'b0);
    test_reset();
    test_alu_beats();
    test_jal();
    test_jalr();
    test_stall();
    test_jump_in_squash();
    test_reset_mid_squash();
`ifdef DECODE_SINK_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_sink.md
Name: decode_sink

Overview:
- Consumer end of the decoded-bundle valid/ready interface; it replaces the fixed `sink_ready_i` tie-off and the ad-hoc one-shot redirect logic in the integration top.
- Accepts decoded beats and retires them in order.
- Resolves JAL/JALR targets, including JALR through a shadowed x1 link register.
- Drives the fetch redirect/flush pulse, then squashes wrong-path beats for a fixed window.

Parameters:
- PC_RESET, 32'h0000_0000, reset value of the link shadow register.
- SQUASH_CYCLES, 2, number of cycles after a redirect pulse during which accepted beats are discarded (range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- dec_valid_i  in  1  decoded beat valid.
- dec_ready_o  out  1  sink ready.
- dec_pc_i  in  32  beat PC.
- dec_instr_i  in  32  raw instruction.
- dec_rs1_i  in  5  source register 1.
- dec_rd_i  in  5  destination register.
- dec_imm_i  in  32  sign-extended immediate.
- dec_is_jump_i  in  1  JAL or JALR.
- stall_i  in  1  downstream throttle; forces ready low while in RUN.
- redir_valid_o  out  1  one-cycle redirect pulse; also used as flush for both skid buffers.
- redir_target_o  out  32  redirect PC.
- retire_valid_o  out  1  registered retire strobe.
- retire_pc_o  out  32  PC of the retired beat.
- retire_count_o  out  32  number of non-squashed beats accepted.

Behaviour:
- Reset (async, rst=1): state=RUN; redir_valid_o=0; redir_target_o=0; retire_valid_o=0; retire_pc_o=0; retire_count_o=0; link=PC_RESET; squash counter=0. Reset asserted mid-REDIR/SQUASH aborts immediately with no pulse emitted.
- Handshake: a beat is accepted when dec_valid_i && dec_ready_o. dec_ready_o is combinational:
  - RUN: !stall_i.
  - REDIR: 0.
  - SQUASH: 1, independent of stall_i.
- State machine RUN / REDIR / SQUASH:
  - RUN, accept of a non-jump beat: retire it and stay in RUN.
  - RUN, accept of a jump beat: retire it, latch the target, go to REDIR.
  - REDIR: lasts exactly one cycle with redir_valid_o=1. Load the squash counter with SQUASH_CYCLES and go to SQUASH.
  - SQUASH: accepted beats are dropped, not retired, not counted, and cannot trigger a redirect. The counter decrements every cycle; when it reaches 1, go to RUN.
- redir_valid_o is registered (high only while in REDIR); redir_target_o holds its value until the next jump is latched.
- Jump resolution: opcode=instr[6:0].
  - 7'b1101111 (JAL): base=dec_pc_i.
  - 7'b1100111 (JALR): base=link if dec_rs1_i==1; 0 if dec_rs1_i==0; otherwise 0.
  - Target = (base+dec_imm_i) mod 2^32, with bits [1:0] forced to 0 (word-aligned fetch).
  - A jump beat with any other opcode retires with no redirect.
- Link shadow: on a retired jump with dec_rd_i==1, link <= dec_pc_i+4. A JALR reading and writing x1 uses the old link value for its target.
- Retire path (latency 1 cycle after accept): retire_valid_o=1 and retire_pc_o=beat PC for one cycle; retire_count_o increments and wraps at 2^32.
- Back-to-back accepts in RUN retire every cycle.
- Jumps are not pipelined: at most one redirect is in flight, and a second jump is seen only after returning to RUN.
- Branches (dec_is_branch) are not a port; branches are treated as not-taken and retired normally.

Optional Feature:
- Macro DECODE_SINK_STATS_EN.
- Defined: adds outputs squash_count_o[15:0] (squashed beats) and redir_count_o[15:0] (redirect pulses). Both are saturating, reset to 0, and each increments by at most 1 per cycle.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cpu_pkg: sink_state_e enum {RUN, REDIR, SQUASH}; opcode constants OPC_JAL=7'b1101111 and OPC_JALR=7'b1100111; localparam LINK_REG=5'd1.
- One sub-module, jump_target_calc: combinational opcode/base selection, add, and alignment.
- The FSM, link register and retire logic stay in decode_sink.

Test Plan:
- Reset then three ALU beats at PC 0x0,0x4,0x8 with stall_i=0 -> retire_valid_o on cycles 1..3 with PCs 0x0,0x4,0x8; retire_count_o=3; redir_valid_o never set.
- JAL rd=1 imm=0x10 at PC 0x8 -> one-cycle redir_valid_o with target 0x18; link=0xC; dec_ready_o=0 in the REDIR cycle; the next 2 accepted beats are not retired.
- After the above, JALR rs1=1 rd=0 imm=0x4 at PC 0x30 -> target 0x10. JALR rs1=1 imm=0x3 with link=0xC -> target 0xC (low bits cleared).
- stall_i=1 held for 4 cycles with dec_valid_i=1 -> dec_ready_o=0, no retire, count unchanged. Release -> beat retires the next cycle.
- A jump beat presented during SQUASH -> dropped, no second redirect. rst pulsed during SQUASH -> all outputs 0 and state RUN on the next edge.
- With DECODE_SINK_STATS_EN: two redirects with SQUASH_CYCLES=2 and valid held high -> redir_count_o=2, squash_count_o=4.
